sprite_table_sched: RTL
=======================

SPRITE_TABLE_SCHED -- requirements
Module: sprite_table_sched

Interface
REQ-001 Parameter: ENTRY_W, 32, width of one sprite table entry (the ppu sprite word).
REQ-002 Port: clock  in  1  system clock, all logic on rising edge.
REQ-003 Port: reset  in  1  asynchronous, active-high.
REQ-004 Port: vsync  in  1  from vga_controller, same clock domain, high during the vertical sync pulse.
REQ-005 Port: req0_valid / req0_ready  in / out  1 / 1  requester 0 (game FSM) handshake.
REQ-006 Port: req0_idx / req0_data  in  1 / ENTRY_W  target entry (0 or 1) and entry value.
REQ-007 Port: req1_valid / req1_ready / req1_idx / req1_data  as req0, requester 1 (animation unit).
REQ-008 Port: sprites  out  2*ENTRY_W  {active[0], active[1]}, feeds the ppu sprites input.
REQ-009 Port: frame_tick  out  1  one-cycle pulse after each commit.
REQ-010 Port: overwrite_cnt  out  8  count of shadow entries rewritten within one frame.

Function
REQ-011 The block SHALL hold two banks of two entries each: shadow (written by requesters) and active (drives sprites).
REQ-012 The FSM SHALL have the states ACCEPT, COMMIT and NOTIFY.
REQ-013 In ACCEPT, a request SHALL be accepted when valid&ready are both high; shadow[idx] <= data at that edge.
REQ-014 When exactly one requester is valid, it SHALL be granted; ready is high only for the granted requester.
REQ-015 When both requesters are valid, round-robin SHALL apply: grant the one not granted last; the last-grant pointer updates on every grant.
REQ-016 At most one write SHALL occur per cycle, so simultaneous requests to the same idx are serialized, not merged.
REQ-017 A vsync rising edge SHALL be detected as vsync=1 with registered vsync_d=0.
REQ-018 On a rising edge in ACCEPT at cycle T, a handshake in T SHALL still complete; the state goes to COMMIT at the end of T.
REQ-019 COMMIT (T+1): both ready low; active <= shadow at the end of the cycle; dirty bits cleared.
REQ-020 NOTIFY (T+2): both ready low, frame_tick=1; the state goes to ACCEPT at the end of the cycle.
REQ-021 Rising edges seen in COMMIT or NOTIFY SHALL be ignored.
REQ-022 sprites SHALL change only at the COMMIT edge; latency from the final accepted write to sprites is at most 2 cycles after the vsync edge.
REQ-023 Each shadow entry SHALL have a dirty bit, set on write.
REQ-024 A write to an entry that is already dirty SHALL be an overwrite event.
REQ-025 A held request (valid high, ready low) SHALL keep idx/data stable; the block does not store it.

Reset
REQ-026 On reset: state=ACCEPT, shadow=0, active=0, sprites=0, dirty=0, vsync_d=1 (no spurious commit if vsync is high at release).
REQ-027 On reset: last-grant pointer=1 (req0 wins the first contention), frame_tick=0, overwrite_cnt=0, ready outputs per REQ-014 from the reset state.
REQ-028 Reset asserted mid-COMMIT/NOTIFY SHALL abort immediately; active SHALL read 0, not a partial copy.

Configuration
REQ-029 Macro SPRITE_OVERWRITE_CNT_EN: when defined, overwrite_cnt SHALL increment by 1 per overwrite event, saturate at 255, and clear only on reset.
REQ-030 Without SPRITE_OVERWRITE_CNT_EN, overwrite_cnt SHALL be constant 0 and dirty tracking may be omitted; all other behaviour is identical.

Verification
REQ-031 req0 writes idx0=0x0000_1234, then vsync rises -> sprites[63:32]=0x0000_1234 two cycles after the edge; frame_tick pulses exactly once, in the cycle after that.
REQ-032 Both valid for 4 cycles after reset -> grants in order req0, req1, req0, req1; one write per cycle.
REQ-033 Handshake in the same cycle as the vsync edge (idx1=0xAB) -> the value appears in the commit; ready is low for the 2 following cycles.
REQ-034 vsync held high for 100 cycles -> exactly one commit and one frame_tick; vsync high at reset release -> no commit.
REQ-035 With the macro defined, 300 writes to idx0 within one frame -> overwrite_cnt=255 (299 events, saturated); without the macro -> overwrite_cnt stays 0.
REQ-036 Reset asserted in the COMMIT cycle -> sprites=0, state ACCEPT, ready high on the next cycle.

Source files
------------

// File: rtl/sprite_table_sched.sv
// -----------------------------------------------------------------------------
// sprite_table_sched
//
// Double-buffered two-entry sprite table shared by two requesters (game FSM and
// animation unit). Requesters write the shadow bank through a valid/ready
// handshake, arbitrated round-robin, one write per cycle. A rising edge on
// vsync copies shadow into the active bank, which drives the ppu, so the ppu
// never sees a half-updated frame.
//
// FSM: ACCEPT (writes allowed, waiting for vsync edge)
//      -> COMMIT (active <= shadow)
//      -> NOTIFY (frame_tick pulse) -> ACCEPT
//
// Ports:
//   clock, reset        rising-edge clock, asynchronous active-high reset
//   vsync               vertical sync level from vga_controller (same domain)
//   req0_valid/ready    requester 0 handshake; req0_idx selects entry 0 or 1,
//   req0_idx/data       req0_data is the new entry value
//   req1_*              same for requester 1
//   sprites             {active[0], active[1]} to the ppu
//   frame_tick          one-cycle pulse in the cycle after each commit
//   overwrite_cnt       saturating count of writes to already-dirty entries
//
// Build option: define SPRITE_OVERWRITE_CNT_EN to enable dirty tracking and
// overwrite_cnt; otherwise overwrite_cnt is tied to 0.
// -----------------------------------------------------------------------------
module sprite_table_sched #(
   parameter int ENTRY_W = 32
) (
   input  logic                   clock,
   input  logic                   reset,
   input  logic                   vsync,
   input  logic                   req0_valid,
   output logic                   req0_ready,
   input  logic                   req0_idx,
   input  logic [ENTRY_W-1:0]     req0_data,
   input  logic                   req1_valid,
   output logic                   req1_ready,
   input  logic                   req1_idx,
   input  logic [ENTRY_W-1:0]     req1_data,
   output logic [2*ENTRY_W-1:0]   sprites,
   output logic                   frame_tick,
   output logic [7:0]             overwrite_cnt
);

   typedef enum logic [1:0] {
      ACCEPT = 2'd0,
      COMMIT = 2'd1,
      NOTIFY = 2'd2
   } state_t;

   state_t               state;
   state_t               state_next;

   logic                 vsync_d;
   logic                 vsync_rise;
   logic                 last_grant;      // 1: req1 was granted last
   logic                 grant0;
   logic                 grant1;
   logic                 wr_en;
   logic                 wr_idx;
   logic [ENTRY_W-1:0]   wr_data;

   logic [ENTRY_W-1:0]   shadow [2];
   logic [ENTRY_W-1:0]   active [2];

   assign vsync_rise = vsync & ~vsync_d;

   // ---------------------------------------------------------------------------
   // FSM: state register
   // ---------------------------------------------------------------------------
   // NOTE: sequential state uses non-blocking assignments so every register
   // samples pre-edge values regardless of process ordering.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) state <= ACCEPT;
      else       state <= state_next;
   end

   // ---------------------------------------------------------------------------
   // FSM: next-state logic. Edges seen outside ACCEPT are simply dropped.
   // ---------------------------------------------------------------------------
   always_comb begin
      // NOTE: default assignment first so no path leaves state_next unassigned
      // (otherwise a latch is inferred).
      state_next = state;
      unique case (state)
         ACCEPT:  if (vsync_rise) state_next = COMMIT;
         COMMIT:  state_next = NOTIFY;
         NOTIFY:  state_next = ACCEPT;
         default: state_next = ACCEPT;
      endcase
   end

   // ---------------------------------------------------------------------------
   // FSM: outputs. Grants only exist in ACCEPT; a lone valid requester wins,
   // contention goes to whoever was not granted last.
   // ---------------------------------------------------------------------------
   always_comb begin
      grant0     = 1'b0;
      grant1     = 1'b0;
      frame_tick = (state == NOTIFY);
      if (state == ACCEPT) begin
         if (req0_valid && req1_valid) begin
            grant0 = last_grant;
            grant1 = ~last_grant;
         end else begin
            grant0 = req0_valid;
            grant1 = req1_valid;
         end
      end
      req0_ready = grant0;
      req1_ready = grant1;
   end

   // Single write port: at most one grant per cycle, so same-idx requests
   // from both sides are serialized by the arbiter.
   assign wr_en   = grant0 | grant1;
   assign wr_idx  = grant1 ? req1_idx  : req0_idx;
   assign wr_data = grant1 ? req1_data : req0_data;

   // ---------------------------------------------------------------------------
   // Datapath: vsync edge detector, arbiter pointer, shadow and active banks.
   // vsync_d resets high so a vsync already high at release is not an edge.
   // ---------------------------------------------------------------------------
   // NOTE: both banks are reset explicitly; they are only four registers and
   // an abort mid-commit must leave active at 0, not at a partial copy.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         vsync_d    <= 1'b1;
         last_grant <= 1'b1;
         for (int i = 0; i < 2; i++) begin
            shadow[i] <= '0;
            active[i] <= '0;
         end
      end else begin
         vsync_d <= vsync;
         if (wr_en) begin
            shadow[wr_idx] <= wr_data;
            last_grant     <= grant1;
         end
         if (state == COMMIT) begin
            for (int i = 0; i < 2; i++) active[i] <= shadow[i];
         end
      end
   end

   assign sprites = {active[0], active[1]};

   // ---------------------------------------------------------------------------
   // Overwrite statistics
   // ---------------------------------------------------------------------------
`ifdef SPRITE_OVERWRITE_CNT_EN
   logic [1:0] dirty;
   logic       overwrite_evt;
   logic [7:0] overwrite_q;

   assign overwrite_evt = wr_en & dirty[wr_idx];

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         dirty       <= '0;
         overwrite_q <= '0;
      end else begin
         // Writes never happen in COMMIT, so the clear cannot race a set.
         if (state == COMMIT) dirty <= '0;
         else if (wr_en)      dirty[wr_idx] <= 1'b1;
         if (overwrite_evt && overwrite_q != 8'hFF)
            overwrite_q <= overwrite_q + 8'd1;
      end
   end

   assign overwrite_cnt = overwrite_q;
`else
   assign overwrite_cnt = 8'd0;
`endif

endmodule
